jogo_timeout_unidade_controle: RTL and testbench

//  Control unit for the memory-game datapath: counter (zeraC/contaC/fimC), switch register (zeraR/registraR) and comparator (igual).

---
 rtl/jogo_timeout_unidade_controle_pkg.sv | 23 ++
 rtl/jogo_timeout_unidade_controle_edge_detector.sv | 19 +
 rtl/jogo_timeout_unidade_controle.sv | 117 +++++++++++
 tb/tb_jogo_timeout_unidade_controle.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/jogo_timeout_unidade_controle_pkg.sv
// State codes shared by the memory-game control unit and the hex-display decoder.
// The encoding is the debug code shown on db_estado.
package jogo_timeout_unidade_controle_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_TIMEOUT = 4'hC,
    VITORIA     = 4'hD,
    DERROTA     = 4'hE
  } estado_t;

  localparam logic [3:0] DB_ILEGAL = 4'hF;

  function automatic logic estado_terminal(input estado_t e);
    return (e == VITORIA) || (e == DERROTA) || (e == FIM_TIMEOUT);
  endfunction

endpackage

// File: rtl/jogo_timeout_unidade_controle_edge_detector.sv
// Rising-edge detector for the player button: one-cycle pulso per low-to-high transition.
// A level already high when reset is released is absorbed during the first cycle.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic sinal_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sinal_q <= 1'b0;
    else        sinal_q <= sinal;
  end

  assign pulso = sinal & ~sinal_q;

endmodule

// File: rtl/jogo_timeout_unidade_controle.sv
// Memory-game control unit with player-paced moves and a per-move idle timeout.
// Moore FSM driving the counter/register/comparator datapath plus a 4-bit debug code.
module jogo_timeout_unidade_controle
  import jogo_timeout_unidade_controle_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       fimC,
  input  logic       igual,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  estado_t       estado, proximo;
  logic [TW-1:0] tmr;
  logic          jogada_edge;

  edge_detector u_edge (
    .clock (clock),
    .reset (reset),
    .sinal (jogada),
    .pulso (jogada_edge)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  // Timer only runs in ESPERA; the FSM leaves ESPERA on TMR_LAST, so it never wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  tmr <= '0;
    else if (estado != ESPERA)   tmr <= '0;
    else if (tmr != TMR_LAST)    tmr <= tmr + TW'(1);
  end

  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:    proximo = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO: proximo = ESPERA;
      // A move arriving on the terminal-count cycle takes priority over the timeout.
      ESPERA: begin
        if (jogada_edge)          proximo = REGISTRA;
        else if (tmr == TMR_LAST) proximo = FIM_TIMEOUT;
        else                      proximo = ESPERA;
      end
      REGISTRA:   proximo = COMPARACAO;
      COMPARACAO: begin
        if (!igual)     proximo = DERROTA;
        else if (fimC)  proximo = VITORIA;
        else            proximo = PROXIMO;
      end
      PROXIMO:    proximo = ESPERA;
      VITORIA, DERROTA, FIM_TIMEOUT:
                  proximo = iniciar ? PREPARACAO : estado;
      default:    proximo = INICIAL;
    endcase
  end

  always_comb begin
    zeraC     = 1'b0;
    zeraR     = 1'b0;
    contaC    = 1'b0;
    registraR = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    pronto    = estado_terminal(estado);
    db_estado = DB_ILEGAL;
    case (estado)
      INICIAL, PREPARACAO: begin
        zeraC     = 1'b1;
        zeraR     = 1'b1;
        db_estado = estado;
      end
      ESPERA, COMPARACAO: db_estado = estado;
      REGISTRA: begin
        registraR = 1'b1;
        db_estado = estado;
      end
      PROXIMO: begin
        contaC    = 1'b1;
        db_estado = estado;
      end
      VITORIA: begin
        acertou   = 1'b1;
        db_estado = estado;
      end
      DERROTA: begin
        errou     = 1'b1;
        db_estado = estado;
      end
      FIM_TIMEOUT: begin
        errou     = 1'b1;
        timeout   = 1'b1;
        db_estado = estado;
      end
      default: db_estado = DB_ILEGAL;
    endcase
  end

endmodule

// File: tb/tb_jogo_timeout_unidade_controle.sv
// Directed bench for the memory-game control unit, TIMEOUT_CYCLES overridden to 8.
module tb_jogo_timeout_unidade_controle;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, jogada, fimC, igual;
  logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int n_cmp = 0;
  int n_err = 0;
  int pulses;

  jogo_timeout_unidade_controle #(.TIMEOUT_CYCLES(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .fimC      (fimC),
    .igual     (igual),
    .zeraC     (zeraC),
    .contaC    (contaC),
    .zeraR     (zeraR),
    .registraR (registraR),
    .pronto    (pronto),
    .acertou   (acertou),
    .errou     (errou),
    .timeout   (timeout),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One player move from ESPERA: edge, REGISTRA, COMPARACAO, then the result state.
  task automatic move(input logic ig, input logic fc, input logic [3:0] exp_res);
    igual  = ig;
    fimC   = fc;
    jogada = 1'b1;
    step(1);
    check_eq("mv_registra", {4'h0, db_estado}, 8'h04);
    check_eq("mv_registraR", {7'h0, registraR}, 8'h01);
    jogada = 1'b0;
    step(1);
    check_eq("mv_comparacao", {4'h0, db_estado}, 8'h05);
    step(1);
    check_eq("mv_result", {4'h0, db_estado}, {4'h0, exp_res});
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; fimC = 1'b0; igual = 1'b0;
    #12;
    check_eq("rst_db", {4'h0, db_estado}, 8'h00);
    check_eq("rst_zera", {6'h0, zeraC, zeraR}, 8'h03);
    check_eq("rst_others", {2'b0, contaC, registraR, pronto, acertou, errou, timeout}, 8'h00);

    // Button held high across reset release must not register a move.
    jogada = 1'b1;
    step(1);
    reset = 1'b1;
    step(1);
    iniciar = 1'b1;
    step(1);
    check_eq("prep", {4'h0, db_estado}, 8'h01);
    iniciar = 1'b0;
    step(2);
    check_eq("held_no_edge", {4'h0, db_estado}, 8'h02);
    jogada = 1'b0;
    step(1);

    // Victory after four moves; contaC pulses once after each of the first three.
    for (int i = 0; i < 3; i++) begin
      move(1'b1, 1'b0, 4'h6);
      check_eq("contaC_hi", {7'h0, contaC}, 8'h01);
      step(1);
      check_eq("contaC_lo", {7'h0, contaC}, 8'h00);
    end
    move(1'b1, 1'b1, 4'hD);
    check_eq("vit_flags", {5'h0, pronto, acertou, errou}, 8'h06);
    step(2);
    check_eq("vit_hold", {4'h0, db_estado}, 8'h0D);
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0;
    check_eq("vit_restart", {4'h0, db_estado}, 8'h01);
    step(1);

    // Defeat on the second move.
    move(1'b1, 1'b0, 4'h6);
    step(1);
    move(1'b0, 1'b0, 4'hE);
    check_eq("der_flags", {4'h0, pronto, acertou, errou, timeout}, 8'h0A);

    // Timeout: eight idle cycles in ESPERA.
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0;
    step(1);
    check_eq("to_espera0", {4'h0, db_estado}, 8'h02);
    step(7);
    check_eq("to_espera7", {4'h0, db_estado}, 8'h02);
    step(1);
    check_eq("to_state", {4'h0, db_estado}, 8'h0C);
    check_eq("to_flags", {5'h0, timeout, errou, pronto}, 8'h07);

    // Edge on the terminal-count cycle wins; button then held for 5 cycles.
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0;
    step(8);
    check_eq("edge_tc_espera", {4'h0, db_estado}, 8'h02);
    igual = 1'b1; fimC = 1'b0; jogada = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (i == 0) begin
        check_eq("edge_tc_state", {4'h0, db_estado}, 8'h04);
        check_eq("edge_tc_noto", {7'h0, timeout}, 8'h00);
      end
      pulses += int'(registraR);
    end
    check_eq("held_pulses", pulses[7:0], 8'h01);
    jogada = 1'b0;
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0;
    check_eq("ini_in_espera", {4'h0, db_estado}, 8'h02);

    // Asynchronous reset while in COMPARACAO.
    jogada = 1'b1;
    step(2);
    check_eq("pre_rst_comp", {4'h0, db_estado}, 8'h05);
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_db", {4'h0, db_estado}, 8'h00);
    check_eq("midrst_zera", {6'h0, zeraC, zeraR}, 8'h03);
    check_eq("midrst_pronto", {7'h0, pronto}, 8'h00);
    jogada = 1'b0;
    step(1);
    reset = 1'b1;
    step(2);
    check_eq("post_rst_idle", {4'h0, db_estado}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
